mmio_sw_led_port: RTL and testbench

- Memory-mapped switch/LED responder on the CPU data bus: the device-side end of the CPU's 8-bit switch input and LED output.
- Synchronises and debounces `i_SW`, records switch edges, and holds the LED register.
- Answers CPU reads and writes with a fixed one-cycle read latency.
- Instanced inside the `part1`-level top between CPU data port and board pins.

---
 rtl/mmio_sw_led_pkg.sv | 13 +
 rtl/mmio_sw_led_port_debounce.sv | 49 ++++
 rtl/mmio_sw_led_port.sv | 96 +++++++++
 tb/tb_mmio_sw_led_port.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mmio_sw_led_pkg.sv
// Shared definitions for the memory-mapped switch/LED port: register map and I/O width.
package mmio_sw_led_pkg;

  localparam int IO_W = 8;

  typedef enum logic [1:0] {
    ADDR_SW_DATA  = 2'd0,
    ADDR_EDGE_CAP = 2'd1,
    ADDR_LEDR     = 2'd2,
    ADDR_IRQ_MASK = 2'd3
  } addr_e;

endpackage

// File: rtl/mmio_sw_led_port_debounce.sv
// Two-flop synchroniser followed by a shared-counter debouncer for a switch bank.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WIDTH           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] debounced,
  output logic [WIDTH-1:0] debounced_next
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sw_sync;
  logic [WIDTH-1:0] candidate;
  logic [CNT_W-1:0] cnt;

  // Exposed so the owner can see an update one cycle early and derive edges.
  always_comb begin
    debounced_next = debounced;
    if ((sw_sync == candidate) && (cnt == CNT_LAST)) begin
      debounced_next = candidate;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1     <= '0;
      sw_sync   <= '0;
      candidate <= '0;
      cnt       <= '0;
      debounced <= '0;
    end else begin
      sync1     <= sw;
      sw_sync   <= sync1;
      debounced <= debounced_next;
      if (sw_sync != candidate) begin
        candidate <= sw_sync;
        cnt       <= '0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_sw_led_port.sv
// Switch/LED bus responder: register file, one-cycle read path, edge capture and irq.
// Define MMIO_SW_EDGE_BOTH_EN to capture falling as well as rising switch edges.
module mmio_sw_led_port
  import mmio_sw_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DATA_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IO_W-1:0]   i_SW,
  input  logic [1:0]        i_addr,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [DATA_W-1:0] i_wrdata,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_rdvalid,
  output logic [IO_W-1:0]   o_LEDR,
  output logic              o_irq
);

  logic [IO_W-1:0] deb;
  logic [IO_W-1:0] deb_next;
  logic [IO_W-1:0] edge_cap;
  logic [IO_W-1:0] irq_mask;
  logic [IO_W-1:0] set_bits;
  logic [IO_W-1:0] clr_bits;
  logic [IO_W-1:0] rd_sel;
  logic            rd_accept;
  addr_e           addr;

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .WIDTH          (IO_W)
  ) u_debounce (
    .clk           (clk),
    .reset         (reset),
    .sw            (i_SW),
    .debounced     (deb),
    .debounced_next(deb_next)
  );

`ifdef MMIO_SW_EDGE_BOTH_EN
  assign set_bits = deb_next ^ deb;
`else
  assign set_bits = deb_next & ~deb;
`endif

  assign addr      = addr_e'(i_addr);
  // A simultaneous write wins over the read; the read is simply dropped.
  assign rd_accept = i_read && !i_write;

  always_comb begin
    clr_bits = '0;
    if (i_write && (addr == ADDR_EDGE_CAP)) begin
      clr_bits = i_wrdata[IO_W-1:0];
    end
  end

  always_comb begin
    rd_sel = '0;
    case (addr)
      ADDR_SW_DATA:  rd_sel = deb;
      ADDR_EDGE_CAP: rd_sel = edge_cap;
      ADDR_LEDR:     rd_sel = o_LEDR;
      ADDR_IRQ_MASK: rd_sel = irq_mask;
      default:       rd_sel = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      o_LEDR    <= '0;
      edge_cap  <= '0;
      irq_mask  <= '0;
      o_rddata  <= '0;
      o_rdvalid <= 1'b0;
      o_irq     <= 1'b0;
    end else begin
      // Set is applied after clear so a same-cycle rise survives a W1C.
      edge_cap  <= (edge_cap & ~clr_bits) | set_bits;
      o_irq     <= |(edge_cap & irq_mask);
      o_rdvalid <= rd_accept;
      if (rd_accept) begin
        o_rddata <= {{(DATA_W - IO_W){1'b0}}, rd_sel};
      end
      if (i_write && (addr == ADDR_LEDR)) begin
        o_LEDR <= i_wrdata[IO_W-1:0];
      end
      if (i_write && (addr == ADDR_IRQ_MASK)) begin
        irq_mask <= i_wrdata[IO_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mmio_sw_led_port.sv
// Bench for mmio_sw_led_port: directed steps then random traffic against a window-based model.
module tb_mmio_sw_led_port;

  localparam int DB     = 4;
  localparam int DATA_W = 16;
  localparam int HIST_N = 16;

  logic              clk;
  logic              reset;
  logic [7:0]        i_SW;
  logic [1:0]        i_addr;
  logic              i_read;
  logic              i_write;
  logic [DATA_W-1:0] i_wrdata;
  logic [DATA_W-1:0] o_rddata;
  logic              o_rdvalid;
  logic [7:0]        o_LEDR;
  logic              o_irq;

  mmio_sw_led_port #(.DEBOUNCE_CYCLES(DB), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_SW     (i_SW),
    .i_addr   (i_addr),
    .i_read   (i_read),
    .i_write  (i_write),
    .i_wrdata (i_wrdata),
    .o_rddata (o_rddata),
    .o_rdvalid(o_rdvalid),
    .o_LEDR   (o_LEDR),
    .o_irq    (o_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int comp_n = 0;
  int fail_n = 0;

  logic [7:0] cur_sw;
  logic [7:0] hist[$];
  logic [7:0] m_deb, m_cap, m_mask, m_led;
  logic [15:0] m_rddata;
  logic m_rdvalid, m_irq;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    comp_n++;
    assert (obs === exp) else begin
      fail_n++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: a raw value becomes the debounced value once DB+1 consecutive
  // samples agree, as seen two clocks later through the synchroniser.
  function automatic logic window_stable(output logic [7:0] v);
    int last = hist.size() - 3;
    v = hist[last];
    for (int k = last - DB; k < last; k++) begin
      if (hist[k] != v) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [7:0] model_reg(input logic [1:0] a);
    case (a)
      2'd0:    return m_deb;
      2'd1:    return m_cap;
      2'd2:    return m_led;
      default: return m_mask;
    endcase
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < HIST_N; k++) hist.push_back(8'h00);
    m_deb = '0; m_cap = '0; m_mask = '0; m_led = '0;
    m_rddata = '0; m_rdvalid = 1'b0; m_irq = 1'b0;
  endtask

  task automatic cycle(input logic rst, input logic rd, input logic wr,
                       input logic [1:0] addr, input logic [15:0] wd);
    logic [7:0] deb_new, v, set_b, clr_b;
    reset = rst; i_SW = cur_sw; i_read = rd; i_write = wr; i_addr = addr; i_wrdata = wd;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      hist.push_back(cur_sw);
      if (hist.size() > HIST_N) void'(hist.pop_front());
      deb_new = m_deb;
      if (window_stable(v)) deb_new = v;
`ifdef MMIO_SW_EDGE_BOTH_EN
      set_b = deb_new ^ m_deb;
`else
      set_b = deb_new & ~m_deb;
`endif
      clr_b = (wr && addr == 2'd1) ? wd[7:0] : 8'h00;
      m_irq = |(m_cap & m_mask);
      m_rdvalid = rd && !wr;
      if (rd && !wr) m_rddata = {8'h00, model_reg(addr)};
      m_cap = (m_cap & ~clr_b) | set_b;
      if (wr && addr == 2'd2) m_led = wd[7:0];
      if (wr && addr == 2'd3) m_mask = wd[7:0];
      m_deb = deb_new;
    end
    #1;
    check("ledr", {8'h00, o_LEDR}, {8'h00, m_led});
    check("irq", {15'h0, o_irq}, {15'h0, m_irq});
    check("rdvalid", {15'h0, o_rdvalid}, {15'h0, m_rdvalid});
    check("rddata", o_rddata, m_rddata);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
    cycle(1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [15:0] d);
    cycle(1'b1, 1'b1, 1'b0, a, 16'h0);
    d = o_rddata;
  endtask

  logic [15:0] rdat;
  int hold;

  initial begin
    model_reset();
    // Reset held with switches high
    cur_sw = 8'hFF;
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
    check("rst_ledr", {8'h00, o_LEDR}, 16'h0000);
    check("rst_rdvalid", {15'h0, o_rdvalid}, 16'h0000);
    check("rst_irq", {15'h0, o_irq}, 16'h0000);
    idle(5);
    rd_reg(2'd0, rdat); check("post_rst_sw_e6", rdat, 16'h0000);
    rd_reg(2'd0, rdat); check("post_rst_sw_e7", rdat, 16'h0000);
    rd_reg(2'd0, rdat); check("post_rst_sw_e8", rdat, 16'h00FF);

    // Clean switch step
    cur_sw = 8'h00; idle(10); wr_reg(2'd1, 16'h00FF);
    cur_sw = 8'hFF; idle(5);
    rd_reg(2'd0, rdat); check("step_sw_e6", rdat, 16'h0000);
    idle(1);
    rd_reg(2'd0, rdat); check("step_sw_e8", rdat, 16'h00FF);
    rd_reg(2'd1, rdat); check("step_cap", rdat, 16'h00FF);

    // Bouncing bit 0
    cur_sw = 8'h00; idle(10); wr_reg(2'd1, 16'h00FF);
    for (int k = 0; k < 10; k++) begin
      cur_sw[0] = ~cur_sw[0];
      idle(2);
      rd_reg(2'd0, rdat); check("bounce_sw", rdat, 16'h0000);
    end
    cur_sw = 8'h01; idle(10);
    rd_reg(2'd0, rdat); check("bounce_hold_sw", rdat, 16'h0001);
    rd_reg(2'd1, rdat); check("bounce_cap", rdat, 16'h0001);
    wr_reg(2'd1, 16'h0001); idle(3);
    rd_reg(2'd1, rdat); check("bounce_cap_once", rdat, 16'h0000);

    // LED write and readback
    wr_reg(2'd2, 16'hABAA);
    check("led_write", {8'h00, o_LEDR}, 16'h00AA);
    rd_reg(2'd2, rdat);
    check("led_read", rdat, 16'h00AA);
    check("led_rdvalid", {15'h0, o_rdvalid}, 16'h0001);
    idle(1);
    check("led_rdvalid_single", {15'h0, o_rdvalid}, 16'h0000);

    // IRQ and write-1-to-clear
    cur_sw = 8'h00; idle(10); wr_reg(2'd1, 16'h00FF);
    wr_reg(2'd3, 16'h0001);
    cur_sw = 8'h01; idle(10);
    check("irq_set", {15'h0, o_irq}, 16'h0001);
    wr_reg(2'd1, 16'h0001);
    check("irq_lag", {15'h0, o_irq}, 16'h0001);
    idle(1);
    check("irq_clear", {15'h0, o_irq}, 16'h0000);
    cur_sw = 8'h00; idle(10); wr_reg(2'd1, 16'h00FF); idle(1);
    cur_sw = 8'h01; idle(6);
    wr_reg(2'd1, 16'h0001);
    rd_reg(2'd1, rdat); check("set_wins", rdat, 16'h0001);

    // Read/write collision
    cycle(1'b1, 1'b1, 1'b1, 2'd3, 16'h005A);
    check("collide_rdvalid", {15'h0, o_rdvalid}, 16'h0000);
    rd_reg(2'd3, rdat); check("collide_read", rdat, 16'h005A);

    // Reset coinciding with a read request
    cycle(1'b0, 1'b1, 1'b0, 2'd2, 16'h0);
    check("rst_read_rdvalid", {15'h0, o_rdvalid}, 16'h0000);
    idle(2);

    // Random traffic
    hold = 0;
    for (int k = 0; k < 400; k++) begin
      if (hold == 0) begin
        cur_sw = 8'($urandom);
        hold = $urandom_range(1, 10);
      end
      hold--;
      cycle(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_n, fail_n);
    $finish;
  end

endmodule
